// File: rtl/rv_regfile_pipe_if.sv
// Register-file access bus: two registered read ports, one write port, ready flag.
interface rv_regfile_pipe_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [XLEN-1:0]   src1_dat;
  logic [XLEN-1:0]   src2_dat;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] tgt;
  logic [XLEN-1:0]   tgt_dat;
  logic              ready;

  modport master (
    output rd_en, src1, src2, wr_en, tgt, tgt_dat,
    input  src1_dat, src2_dat, rd_valid, ready
  );

  modport slave (
    input  rd_en, src1, src2, wr_en, tgt, tgt_dat,
    output src1_dat, src2_dat, rd_valid, ready
  );
endinterface

// File: rtl/rv_regfile_pipe.sv
// Two-read/one-write register file with a post-reset clear walk and 1-cycle registered reads.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module rv_regfile_pipe #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  rv_regfile_pipe_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [XLEN-1:0]   regs [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic              rd_fire;
  logic [XLEN-1:0]   rd1_val, rd2_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR)
        cnt <= cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        if (cnt == '1)
          state_next = IDLE;
      end
      IDLE: begin
        mem_we   = bus.wr_en && !((ZERO_REG != 0) && (bus.tgt == '0));
        mem_addr = bus.tgt;
        mem_data = bus.tgt_dat;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Storage has no reset; the clear walk is what zeroes it, and a write coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      regs[mem_addr] <= mem_data;
  end

  always_comb begin
    rd1_val = regs[bus.src1];
    rd2_val = regs[bus.src2];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.tgt == bus.src1))
      rd1_val = bus.tgt_dat;
    if (bus.wr_en && (bus.tgt == bus.src2))
      rd2_val = bus.tgt_dat;
`endif
    if ((ZERO_REG != 0) && (bus.src1 == '0))
      rd1_val = '0;
    if ((ZERO_REG != 0) && (bus.src2 == '0))
      rd2_val = '0;
  end

  assign rd_fire = (state == IDLE) && bus.rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.src1_dat <= '0;
      bus.src2_dat <= '0;
    end else begin
      bus.rd_valid <= rd_fire;
      if (rd_fire) begin
        bus.src1_dat <= rd1_val;
        bus.src2_dat <= rd2_val;
      end
    end
  end

  assign bus.ready = (state == IDLE);
endmodule

// File: tb/tb_rv_regfile_pipe.sv
// Directed self-checking bench for rv_regfile_pipe (XLEN=32, ADDR_W=5, ZERO_REG=1).
module tb_rv_regfile_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rv_regfile_pipe_if #(.XLEN(32), .ADDR_W(5)) bus ();

  rv_regfile_pipe #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [4:0] s1, input logic [4:0] s2,
                               input logic wr, input logic [4:0] t, input logic [31:0] d);
    bus.rd_en   = rd;
    bus.src1    = s1;
    bus.src2    = s2;
    bus.wr_en   = wr;
    bus.tgt     = t;
    bus.tgt_dat = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRead(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    checkOutput({tag, "_valid"}, {31'b0, bus.rd_valid}, 32'd1);
    checkOutput({tag, "_src1"}, bus.src1_dat, e1);
    checkOutput({tag, "_src2"}, bus.src2_dat, e2);
  endtask

  task automatic writeReg(input logic [4:0] t, input logic [31:0] d);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, t, d);
    tick();
  endtask

  task automatic runClear(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      checkOutput(tag, {31'b0, bus.ready}, (i == 32) ? 32'd1 : 32'd0);
      if (i < 32)
        checkOutput({tag, "_novalid"}, {31'b0, bus.rd_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] exp_byp1;
    logic [31:0] exp_byp2;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("rst_valid", {31'b0, bus.rd_valid}, 32'd0);
    checkOutput("rst_src1", bus.src1_dat, 32'd0);
    checkOutput("rst_src2", bus.src2_dat, 32'd0);

    // Requests during the clear walk must be ignored, including a late write to reg 9.
    applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D);
    rst_n = 1'b1;
    runClear("clear1_ready");

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0);
      tick();
      checkRead("zero_sweep", 32'd0, 32'd0);
    end

    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("idle_valid", {31'b0, bus.rd_valid}, 32'd0);

    writeReg(5'd5, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkRead("rd5", 32'hDEADBEEF, 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("rd5_pulse_end", {31'b0, bus.rd_valid}, 32'd0);
    checkOutput("rd5_hold", bus.src1_dat, 32'hDEADBEEF);

    writeReg(5'd0, 32'h12345678);
    applyStimulus(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0);
    tick();
    checkRead("zero_reg", 32'd0, 32'hDEADBEEF);

    applyStimulus(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    tick();
    checkRead("same_addr", 32'hDEADBEEF, 32'hDEADBEEF);

    writeReg(5'd7, 32'h1);
`ifdef REGFILE_BYPASS_EN
    exp_byp1 = 32'h2;
    exp_byp2 = 32'h88;
`else
    exp_byp1 = 32'h1;
    exp_byp2 = 32'h0;
`endif
    applyStimulus(1'b1, 5'd7, 5'd5, 1'b1, 5'd7, 32'h2);
    tick();
    checkRead("bypass_p1", exp_byp1, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd7, 5'd8, 1'b1, 5'd8, 32'h88);
    tick();
    checkRead("bypass_p2", 32'h2, exp_byp2);
    applyStimulus(1'b1, 5'd0, 5'd8, 1'b1, 5'd0, 32'h99);
    tick();
    checkRead("bypass_zero", 32'd0, 32'h88);

    writeReg(5'd1, 32'h11);
    writeReg(5'd2, 32'h22);
    writeReg(5'd3, 32'h33);
    writeReg(5'd4, 32'h44);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 5'(5 - i), 1'b0, 5'd0, 32'd0);
      tick();
      checkRead("b2b", 32'(i * 32'h11), 32'((5 - i) * 32'h11));
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("b2b_end", {31'b0, bus.rd_valid}, 32'd0);

    // Mid-operation reset with a coincident write and read.
    writeReg(5'd3, 32'hAAAA5555);
    applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'hFFFFFFFF);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("mid_rst_valid", {31'b0, bus.rd_valid}, 32'd0);
    checkOutput("mid_rst_src1", bus.src1_dat, 32'd0);
    checkOutput("mid_rst_src2", bus.src2_dat, 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    runClear("clear2_ready");

    applyStimulus(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'd0);
    tick();
    checkRead("post_rst", 32'd0, 32'd0);
    applyStimulus(1'b1, 5'd9, 5'd7, 1'b0, 5'd0, 32'd0);
    tick();
    checkRead("post_rst2", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
